// File: rtl/sipo_loader.sv
// Serial-in, parallel-out frame assembler. It collects N start-framed serial bits into pdo
// and pulses pl in the same cycle so a downstream parallel-load register captures pdo directly.
module sipo_loader #(
  parameter int unsigned N         = 12,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sin,
  input  logic         sin_vld,
  output logic [N-1:0] pdo,
  output logic         pl,
  output logic         busy,
  output logic         abort
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e         r_state, w_state_d;
  logic [N-1:0]   r_sr, w_sr_d;
  logic [CW-1:0]  r_cnt, w_cnt_d;
  logic [N-1:0]   r_pdo, w_pdo_d;
  logic           r_pl, w_pl_d;
  logic           r_abort, w_abort_d;
  logic [N-1:0]   w_sr_shift;

  // Bit order is fixed at elaboration; the current sin is always folded into the shifted word.
  assign w_sr_shift = (MSB_FIRST != 0) ? {r_sr[N-2:0], sin} : {sin, r_sr[N-1:1]};

  always_comb begin
    w_state_d = r_state;
    w_sr_d    = r_sr;
    w_cnt_d   = r_cnt;
    w_pdo_d   = r_pdo;
    w_pl_d    = 1'b0;
    w_abort_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StShift;
          w_sr_d    = '0;
          w_cnt_d   = '0;
        end
      end
      StShift: begin
        // start has priority over data, even on what would be the final bit.
        if (start) begin
          w_abort_d = 1'b1;
          w_sr_d    = '0;
          w_cnt_d   = '0;
        end else if (sin_vld) begin
          w_sr_d = w_sr_shift;
          if (r_cnt == LastCnt) begin
            w_pdo_d   = w_sr_shift;
            w_pl_d    = 1'b1;
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_pdo   <= '0;
      r_pl    <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sr    <= w_sr_d;
      r_cnt   <= w_cnt_d;
      r_pdo   <= w_pdo_d;
      r_pl    <= w_pl_d;
      r_abort <= w_abort_d;
    end
  end

  assign pdo   = r_pdo;
  assign pl    = r_pl;
  assign abort = r_abort;
  assign busy  = (r_state == StShift);

endmodule

// File: tb/tb_sipo_loader.sv
// Directed bench for sipo_loader: one MSB-first and one LSB-first instance share the stimulus.
module tb_sipo_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sin;
  logic        sin_vld;
  logic [11:0] pdo_m, pdo_l;
  logic        pl_m, pl_l, busy_m, busy_l, abort_m, abort_l;

  int n_vec;
  int n_err;

  sipo_loader #(.N(12), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_vld(sin_vld),
    .pdo(pdo_m), .pl(pl_m), .busy(busy_m), .abort(abort_m)
  );

  sipo_loader #(.N(12), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_vld(sin_vld),
    .pdo(pdo_l), .pl(pl_l), .busy(busy_l), .abort(abort_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic d, input logic v);
    start   = s;
    sin     = d;
    sin_vld = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({pdo_m, pl_m, busy_m, abort_m} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_async: got pdo=%h pl=%b busy=%b abort=%b want all 0",
               pdo_m, pl_m, busy_m, abort_m);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({pdo_l, pl_l, busy_l, abort_l} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_hold: got pdo=%h pl=%b busy=%b abort=%b want all 0",
               pdo_l, pl_l, busy_l, abort_l);
    end
  endtask

  task automatic test_msb_frame();
    logic [11:0] w;
    int busy_cnt;
    int cyc;
    w = 12'hAC3;
    busy_cnt = 0;
    cyc = 0;
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    cyc++;
    if (busy_m) busy_cnt++;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, w[11-i], 1'b1);
      tick();
      cyc++;
      if (busy_m) busy_cnt++;
      if (i < 11) begin
        n_vec++;
        if ({pl_m, busy_m, abort_m} !== 3'b010) begin
          n_err++;
          $display("FAIL msb_midframe bit%0d: got pl=%b busy=%b abort=%b want 0/1/0",
                   i, pl_m, busy_m, abort_m);
        end
      end
    end
    n_vec++;
    if (pl_m !== 1'b1 || pdo_m !== 12'hAC3 || cyc != 13) begin
      n_err++;
      $display("FAIL msb_complete: got pl=%b pdo=%h cycles=%0d want pl=1 pdo=ac3 cycles=13",
               pl_m, pdo_m, cyc);
    end
    n_vec++;
    if (busy_cnt != 12) begin
      n_err++;
      $display("FAIL msb_busy_len: got %0d want 12", busy_cnt);
    end
    set_in(1'b0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (pl_m !== 1'b0 || pdo_m !== 12'hAC3 || busy_m !== 1'b0) begin
      n_err++;
      $display("FAIL msb_after: got pl=%b pdo=%h busy=%b want pl=0 pdo=ac3 busy=0",
               pl_m, pdo_m, busy_m);
    end
  endtask

  task automatic test_gapped();
    logic [11:0] w;
    int cyc;
    w = 12'hAC3;
    cyc = 0;
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    cyc++;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        for (int g = 0; g < 3; g++) begin
          set_in(1'b0, 1'b1, 1'b0);
          tick();
          cyc++;
          n_vec++;
          if ({pl_m, busy_m} !== 2'b01) begin
            n_err++;
            $display("FAIL gap_hold%0d: got pl=%b busy=%b want 0/1", g, pl_m, busy_m);
          end
        end
      end
      set_in(1'b0, w[11-i], 1'b1);
      tick();
      cyc++;
    end
    n_vec++;
    if (pl_m !== 1'b1 || pdo_m !== 12'hAC3 || cyc != 16) begin
      n_err++;
      $display("FAIL gap_complete: got pl=%b pdo=%h cycles=%0d want pl=1 pdo=ac3 cycles=16",
               pl_m, pdo_m, cyc);
    end
    set_in(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_lsb_frame();
    int pl_cnt;
    pl_cnt = 0;
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, (i == 0), 1'b1);
      tick();
      if (pl_l) pl_cnt++;
    end
    n_vec++;
    if (pl_l !== 1'b1 || pdo_l !== 12'h001) begin
      n_err++;
      $display("FAIL lsb_complete: got pl=%b pdo=%h want pl=1 pdo=001", pl_l, pdo_l);
    end
    n_vec++;
    if (pdo_m !== 12'h800) begin
      n_err++;
      $display("FAIL lsb_msb_twin: got pdo=%h want 800", pdo_m);
    end
    set_in(1'b0, 1'b0, 1'b0);
    tick();
    if (pl_l) pl_cnt++;
    n_vec++;
    if (pl_cnt != 1 || pdo_l !== 12'h001) begin
      n_err++;
      $display("FAIL lsb_single_pl: got pulses=%0d pdo=%h want 1 pulse pdo=001", pl_cnt, pdo_l);
    end
  endtask

  task automatic test_abort_restart();
    logic [11:0] w;
    int abort_cnt;
    int pdo_bad;
    w = 12'hAC3;
    abort_cnt = 0;
    pdo_bad = 0;
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, w[11-i], 1'b1);
      tick();
    end
    n_vec++;
    if (pl_m !== 1'b1 || pdo_m !== 12'hAC3) begin
      n_err++;
      $display("FAIL abort_pre: got pl=%b pdo=%h want pl=1 pdo=ac3", pl_m, pdo_m);
    end
    // start is raised while pl is high: back-to-back frame
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({pl_m, busy_m, abort_m} !== 3'b010 || pdo_m !== 12'hAC3) begin
      n_err++;
      $display("FAIL b2b_start: got pl=%b busy=%b abort=%b pdo=%h want 0/1/0 ac3",
               pl_m, busy_m, abort_m, pdo_m);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b1, 1'b1);
      tick();
      if (abort_m) abort_cnt++;
      if (pdo_m !== 12'hAC3) pdo_bad++;
    end
    set_in(1'b1, 1'b1, 1'b1);
    tick();
    if (abort_m) abort_cnt++;
    n_vec++;
    if ({pl_m, busy_m, abort_m} !== 3'b011 || pdo_m !== 12'hAC3) begin
      n_err++;
      $display("FAIL abort_pulse: got pl=%b busy=%b abort=%b pdo=%h want 0/1/1 ac3",
               pl_m, busy_m, abort_m, pdo_m);
    end
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, 1'b1, 1'b1);
      tick();
      if (abort_m) abort_cnt++;
      if (i < 11 && (pdo_m !== 12'hAC3 || pl_m !== 1'b0)) pdo_bad++;
    end
    n_vec++;
    if (pl_m !== 1'b1 || pdo_m !== 12'hFFF) begin
      n_err++;
      $display("FAIL abort_restart: got pl=%b pdo=%h want pl=1 pdo=fff", pl_m, pdo_m);
    end
    n_vec++;
    if (abort_cnt != 1 || pdo_bad != 0) begin
      n_err++;
      $display("FAIL abort_count: got aborts=%0d early_changes=%0d want 1 and 0",
               abort_cnt, pdo_bad);
    end
    set_in(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_start_last();
    logic [11:0] w;
    w = 12'h3C5;
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 11; i++) begin
      set_in(1'b0, w[11-i], 1'b1);
      tick();
    end
    set_in(1'b1, w[0], 1'b1);
    tick();
    n_vec++;
    if ({pl_m, busy_m, abort_m} !== 3'b011 || pdo_m !== 12'hFFF) begin
      n_err++;
      $display("FAIL start_last: got pl=%b busy=%b abort=%b pdo=%h want 0/1/1 fff",
               pl_m, busy_m, abort_m, pdo_m);
    end
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, w[11-i], 1'b1);
      tick();
    end
    n_vec++;
    if (pl_m !== 1'b1 || pdo_m !== 12'h3C5 || abort_m !== 1'b0) begin
      n_err++;
      $display("FAIL start_last_next: got pl=%b pdo=%h abort=%b want pl=1 pdo=3c5 abort=0",
               pl_m, pdo_m, abort_m);
    end
    set_in(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [11:0] w;
    int pl_cnt;
    w = 12'h96B;
    pl_cnt = 0;
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b1, 1'b1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({pdo_m, pl_m, busy_m, abort_m} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_mid: got pdo=%h pl=%b busy=%b abort=%b want all 0",
               pdo_m, pl_m, busy_m, abort_m);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b1, 1'b1);
      tick();
      if (pl_m || busy_m) pl_cnt++;
    end
    n_vec++;
    if (pl_cnt != 0 || pdo_m !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid_after: got stray=%0d pdo=%h want 0 and 000", pl_cnt, pdo_m);
    end
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, w[11-i], 1'b1);
      tick();
    end
    n_vec++;
    if (pl_m !== 1'b1 || pdo_m !== 12'h96B) begin
      n_err++;
      $display("FAIL reset_mid_next: got pl=%b pdo=%h want pl=1 pdo=96b", pl_m, pdo_m);
    end
    set_in(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_msb_frame();
    test_gapped();
    test_lsb_frame();
    test_abort_restart();
    test_start_last();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_loader.md
# sipo_loader

Serial-in, parallel-out frame assembler that produces the parallel-load strobe and data word for an N-bit parallel-load register. It collects N serial bits framed by a start strobe and presents the assembled word on `pdo`. In the same cycle it pulses `pl` so the downstream register captures `pdo` directly. It sits between a one-bit serial source and the register's `pl`/`di` inputs.

## Interface
- `N`, default 12: word width in bits; legal values are N ≥ 2.
- `MSB_FIRST`, default 1: bit order. 1 = the first received bit lands in `pdo[N-1]`. 0 = the first received bit lands in `pdo[0]`.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Frame start strobe, sampled on each rising edge.
- `sin`: input, 1 bit. Serial data bit.
- `sin_vld`: input, 1 bit. `sin` is valid this cycle.
- `pdo`: output, N bits. Last completed word; connects to the register's `di`.
- `pl`: output, 1 bit. One-cycle load strobe; connects to the register's `pl`.
- `busy`: output, 1 bit. A frame is in progress.
- `abort`: output, 1 bit. One-cycle pulse when an in-progress frame is discarded by `start`.

## Operation
- **FSM states:** IDLE and SHIFT. Internal state is an N-bit shift register `sr` and a bit counter `cnt` of width clog2(N).
- **Reset:** `rst_n`=0 immediately forces the following, regardless of `clk`:
  - state = IDLE
  - `sr` = 0, `cnt` = 0
  - `pdo` = 0, `pl` = 0, `busy` = 0, `abort` = 0
- **IDLE:**
  - `sin_vld` is ignored.
  - `start`=1 → next state SHIFT, `cnt` ← 0, `sr` ← 0.
- **SHIFT, normal capture:** on each edge with `sin_vld`=1 and `start`=0:
  - MSB_FIRST=1: `sr` ← {sr[N-2:0], sin}.
  - MSB_FIRST=0: `sr` ← {sin, sr[N-1:1]}.
  - `cnt` increments.
- **SHIFT, idle cycles:** `sin_vld`=0 holds `sr` and `cnt`. There is no timeout.
- **SHIFT, completion:** a capture edge with `cnt`=N-1 completes the frame. On that edge:
  - `pdo` ← the assembled word, including the current `sin`.
  - `pl` ← 1.
  - next state IDLE, `cnt` ← 0.
- **Abort:** `start`=1 while in SHIFT aborts the current frame.
  - `abort` ← 1 for one cycle; `cnt` ← 0, `sr` ← 0; state stays SHIFT.
  - `sin` in that cycle is discarded.
  - `pdo` is unchanged and `pl` is not asserted.
- **Start on the last bit:** `start`=1 on the same edge as the would-be Nth bit → `start` wins. The frame is aborted as above, with no `pl` and `pdo` unchanged.
- **`pdo` hold rule:** `pdo` changes only on completion and holds its value indefinitely otherwise.
- **Output derivation:**
  - `busy` = (state == SHIFT), registered.
  - `pl` and `abort` are registered single-cycle pulses and are never high simultaneously.
- **Back-to-back frames:** `start` may be asserted in the cycle `pl` is high. State is IDLE then, so a new frame begins normally.

## Timing
- With `start` sampled at edge 0 and `sin_vld` continuously high from cycle 1:
  - `busy`=1 from edge 0 through edge N.
  - Bits are captured at edges 1..N.
  - `pl`=1 and the new `pdo` are valid in the cycle after edge N, which is N+1 cycles after `start`.
- Each `sin_vld`=0 cycle during SHIFT delays completion by exactly one cycle.
- `pdo` is stable for the whole cycle in which `pl`=1, so the register captures it directly.
- **Minimum frame period:** N+1 cycles (`start` in the `pl` cycle).
- **Reset mid-frame:** partial data is lost, `pl` never fires for that frame, and `pdo` reads 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
1. **MSB-first frame:** N=12, MSB_FIRST=1; `start`, then bits 1,0,1,0,1,1,0,0,0,0,1,1 with `sin_vld` continuous → `pl` high exactly one cycle, 13 cycles after `start`, with `pdo`=12'hAC3. `busy` is high for 12 cycles.
2. **Gapped input:** same word with 3 `sin_vld`=0 cycles inserted after bit 5 → `pdo`=12'hAC3, `pl` 3 cycles later than in scenario 1.
3. **LSB-first frame:** MSB_FIRST=0; bits 1 followed by eleven 0s → `pdo`=12'h001, one `pl` pulse.
4. **Abort and restart:** complete 12'hAC3; then `start`, 5 bits, `start` again, then 12 ones → exactly one `abort` pulse. `pdo` stays 12'hAC3 until the final `pl`, after which `pdo`=12'hFFF.
5. **Start on the last bit:** `start` asserted together with the 12th `sin_vld` → no `pl`, `abort`=1, `busy` stays 1. A following 12-bit frame completes normally.
6. **Reset mid-frame:** `rst_n` pulsed low after 6 bits → `pdo`=0, `pl`=`busy`=`abort`=0 immediately, with no `pl` afterward. The next full frame completes with the correct `pdo`.
